decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage of the RV32I core. Accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses. It captures operand data from the register file, which registers its read data on posedge and writes on negedge. It also generates immediates and control signals, then presents a registered ID/EX bundle to execute. It covers the register file's write-cycle read suppression by stalling, and forwards same-cycle writeback data.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register address width
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- rf_a1 / rf_a2  out  REG_AW  register-file read addresses (rs1 / rs2)
- rf_rd1 / rf_rd2  in  XLEN  register-file read data, registered on posedge
- wb_we  in  1  writeback write enable, same signal driving the register-file write enable
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  discard contents (branch taken)
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  operands
- out_rd  out  REG_AW  destination register
- out_funct3  out  3  funct3 field
- out_funct7b5  out  1  instr[30]
- out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1  control signals

## Operation
- FSM states: S_EMPTY, S_READ, S_DATA, S_VALID.
- S_EMPTY: in_ready=1. On in_valid, latch instr_q and pc_q, then go to S_READ.
- S_READ: rf_a1=instr_q[19:15], rf_a2=instr_q[24:20]. These addresses are driven from instr_q in every state.
  - wb_we=1: stay in S_READ. The register file suppresses reads during write cycles.
  - wb_we=0: go to S_DATA. The register file latches read data on this edge.
- S_DATA: the bundle register captures decoded fields and operands, then go to S_VALID.
  - rs1 operand: 0 if rs1==0.
  - Otherwise, if wb_we && wb_rd==rs1, use wb_data, because a negedge write in this cycle makes rf_rd1 stale.
  - Otherwise use rf_rd1.
  - rs2 operand follows the same rule with rs2 and rf_rd2.
- S_VALID: out_valid=1. in_ready=out_ready.
  - out_ready && in_valid: latch the new instruction, go to S_READ.
  - out_ready && !in_valid: go to S_EMPTY.
  - Otherwise hold the bundle unchanged.
- Immediate by opcode:
  - I-type (0x03, 0x13, 0x67): sext instr[31:20].
  - S-type (0x23): sext {instr[31:25], instr[11:7]}.
  - B-type (0x63): sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0x37, 0x17): {instr[31:12], 12'b0}.
  - J-type (0x6F): sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign extension is to XLEN.
- Control by opcode:
  - reg_write=1 for 0x33, 0x13, 0x03, 0x37, 0x17, 0x6F, 0x67.
  - mem_read=1 for 0x03.
  - mem_write=1 for 0x23.
  - branch=1 for 0x63.
  - jump=1 for 0x6F, 0x67.
  - alu_src=1 for every opcode except 0x33 and 0x63.
- Unknown opcode: out_illegal=1, all other controls 0, imm=0. The bundle is still passed downstream.

## Timing
- Reset: state S_EMPTY, in_ready=0 during reset, out_valid=0. All out_* data and control outputs are 0. instr_q=0, so rf_a1=rf_a2=0.
- Latency without stalls: accept at edge E0, register-file latch at E1, out_valid high after E2 (2 cycles).
- Each cycle of wb_we=1 while in S_READ adds one cycle of latency.
- Throughput is at most one instruction per 3 cycles. Back-to-back acceptance from S_VALID skips S_EMPTY.
- flush outranks everything except rst. On the flush edge: state goes to S_EMPTY, out_valid=0, and the input handshake in that cycle is ignored (in_ready=0 while flush=1).
- Reset mid-operation discards the in-flight instruction. No partial bundle is ever emitted.
- While out_valid=1 and out_ready=0, every out_* signal stays stable.

## Structure
- Shared package decode_pkg holds:
  - state enum (S_EMPTY..S_VALID)
  - opcode localparams (OP_LOAD=0x03, OP_IMM=0x13, OP_AUIPC=0x17, OP_STORE=0x23, OP_REG=0x33, OP_LUI=0x37, OP_BRANCH=0x63, OP_JALR=0x67, OP_JAL=0x6F)
  - imm-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE)
  - packed struct for the ID/EX bundle
- One combinational sub-module, imm_gen (instr → format, imm).

## Test plan
- After reset, in_valid=1, instr 0xFFD08293 (addi x5,x1,-3), x1 holds 10 → after 2 cycles: out_valid=1, rs1_data=10, imm=0xFFFFFFFD, rd=5, alu_src=1, reg_write=1.
- sw x2,8(x3) (0x0021A423) with wb_we=1 held 2 cycles in S_READ → out_valid appears 4 cycles after accept; imm=8, mem_write=1, reg_write=0.
- In S_DATA, wb_we=1, wb_rd=1, wb_data=0x55 for the addi above → rs1_data=0x55.
- rs1=x0 with wb_we=1, wb_rd=0, wb_data=7 → rs1_data=0.
- out_ready=0 for 5 cycles → bundle stable and in_ready=0. Then flush=1 → out_valid=0 next cycle, state S_EMPTY.
- Opcode 0x7F → out_illegal=1, all other controls 0, imm=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I decode stage.
package decode_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_READ,
        S_DATA,
        S_VALID
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    // ID/EX bundle handed to execute
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              illegal;
    } idex_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: classifies the instruction format and builds the
// sign-extended immediate. Purely combinational.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0]     instr,
    output imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    // Pick the immediate format from the opcode
    always_comb begin
        fmt = IMM_NONE;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
    end

    // Assemble the immediate bits for the chosen format, sign-extended to XLEN
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: accepts an instruction, reads the register file
// (waiting out write cycles, which suppress reads), forwards same-cycle
// writeback data and presents a registered ID/EX bundle to execute.
module decode_stage
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] rf_a1,
    output logic [REG_AW-1:0] rf_a2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_rd,
    output logic [2:0]        out_funct3,
    output logic              out_funct7b5,
    output logic              out_alu_src,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_illegal
);

    state_t          state;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    idex_t           bundle;
    idex_t           next_bundle;

    imm_fmt_t        fmt;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    imm_gen u_imm_gen (
        .instr (instr_q),
        .fmt   (fmt),
        .imm   (imm)
    );

    assign opcode = instr_q[6:0];
    assign rf_a1  = instr_q[19:15];
    assign rf_a2  = instr_q[24:20];

    // A negedge write during S_DATA lands after rf_rd* was latched, so take wb_data instead
    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
        if (rf_a1 == '0)
            rs1_val = '0;
        else if (wb_we && wb_rd == rf_a1)
            rs1_val = wb_data;
        if (rf_a2 == '0)
            rs2_val = '0;
        else if (wb_we && wb_rd == rf_a2)
            rs2_val = wb_data;
    end

    // Decode control signals and assemble the bundle captured at the end of S_DATA
    always_comb begin
        next_bundle           = '0;
        next_bundle.pc        = pc_q;
        next_bundle.rs1_data  = rs1_val;
        next_bundle.rs2_data  = rs2_val;
        next_bundle.imm       = imm;
        next_bundle.rd        = instr_q[11:7];
        next_bundle.funct3    = instr_q[14:12];
        next_bundle.funct7b5  = instr_q[30];
        // Only R-type has no immediate among the legal opcodes
        next_bundle.illegal   = (fmt == IMM_NONE) && (opcode != OP_REG);
        case (opcode)
            OP_LOAD: begin
                next_bundle.alu_src   = 1'b1;
                next_bundle.reg_write = 1'b1;
                next_bundle.mem_read  = 1'b1;
            end
            OP_IMM, OP_AUIPC, OP_LUI: begin
                next_bundle.alu_src   = 1'b1;
                next_bundle.reg_write = 1'b1;
            end
            OP_STORE: begin
                next_bundle.alu_src   = 1'b1;
                next_bundle.mem_write = 1'b1;
            end
            OP_REG: begin
                next_bundle.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                next_bundle.branch    = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                next_bundle.alu_src   = 1'b1;
                next_bundle.reg_write = 1'b1;
                next_bundle.jump      = 1'b1;
            end
            default: begin
                next_bundle.alu_src   = 1'b0;
            end
        endcase
    end

    // Stage FSM: capture instruction, wait for a read-enabled edge, capture bundle, hand off
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
            bundle  <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        pc_q    <= in_pc;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (!wb_we)
                        state <= S_DATA;
                end
                S_DATA: begin
                    bundle <= next_bundle;
                    state  <= S_VALID;
                end
                S_VALID: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            instr_q <= in_instr;
                            pc_q    <= in_pc;
                            state   <= S_READ;
                        end else begin
                            state <= S_EMPTY;
                        end
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign in_ready = !rst && !flush &&
                      ((state == S_EMPTY) || ((state == S_VALID) && out_ready));
    assign out_valid     = (state == S_VALID);
    assign out_pc        = bundle.pc;
    assign out_rs1_data  = bundle.rs1_data;
    assign out_rs2_data  = bundle.rs2_data;
    assign out_imm       = bundle.imm;
    assign out_rd        = bundle.rd;
    assign out_funct3    = bundle.funct3;
    assign out_funct7b5  = bundle.funct7b5;
    assign out_alu_src   = bundle.alu_src;
    assign out_reg_write = bundle.reg_write;
    assign out_mem_read  = bundle.mem_read;
    assign out_mem_write = bundle.mem_write;
    assign out_branch    = bundle.branch;
    assign out_jump      = bundle.jump;
    assign out_illegal   = bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: behavioural register file, directed scenarios
// and randomized instructions checked against an opcode-level decode model.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_alu_src, out_reg_write, out_mem_read;
    logic        out_mem_write, out_branch, out_jump, out_illegal;

    logic [31:0] rf_mem [32];
    int n_assert = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_a1(rf_a1), .rf_a2(rf_a2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Register file: writes on negedge, read data registered on posedge, reads suppressed while writing
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] = (i == 0) ? 32'd0 : ((i == 1) ? 32'd10 : 32'h1000 + 32'(i));
        end else if (wb_we && wb_rd != 5'd0) begin
            rf_mem[wb_rd] = wb_data;
        end
    end

    always @(posedge clk) begin
        if (!wb_we) begin
            rf_rd1 <= rf_mem[rf_a1];
            rf_rd2 <= rf_mem[rf_a2];
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Immediate from the ISA's bit-placement rules, using signed integer arithmetic
    function automatic logic [31:0] model_imm(input logic [31:0] ins);
        int s;
        int r;
        s = $signed(ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: r = s >>> 20;
            7'h23: r = (s >>> 25) * 32 + int'(ins[11:7]);
            7'h63: r = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                       + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            7'h37, 7'h17: r = s & 32'hFFFFF000;
            7'h6F: r = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096
                       + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: r = 0;
        endcase
        return 32'(r);
    endfunction

    // Control vector {alu_src, reg_write, mem_read, mem_write, branch, jump, illegal}
    function automatic logic [6:0] model_ctrl(input logic [6:0] op);
        logic known;
        known = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        if (!known) return 7'b0000001;
        return {!(op inside {7'h33, 7'h63}),
                op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67},
                op == 7'h03, op == 7'h23, op == 7'h63,
                op inside {7'h6F, 7'h67}, 1'b0};
    endfunction

    // One full transaction: offer, stall nstall write cycles, optional writeback in S_DATA, check bundle
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                                 input int nstall, input int fwd_mode, input logic [31:0] fwd_data);
        int waited;
        logic early;
        logic [4:0] rs1, rs2;
        logic [31:0] exp1, exp2;
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        early = 1'b0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1; wb_we = 1'b0;
        #1;
        waited = 0;
        while (!in_ready && waited < 8) begin
            tick();
            waited++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_instr = $urandom; in_pc = $urandom; out_ready = 1'b0;
        checkOutput("rf_a1", 32'(rf_a1), 32'(rs1));
        for (int k = 0; k < nstall; k++) begin
            wb_we = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
            tick();
            if (out_valid) early = 1'b1;
        end
        wb_we = 1'b0;
        tick();
        if (out_valid) early = 1'b1;
        case (fwd_mode)
            1: begin wb_we = 1'b1; wb_rd = rs1; end
            2: begin wb_we = 1'b1; wb_rd = rs2; end
            3: begin wb_we = 1'b1; wb_rd = 5'($urandom_range(1, 31)); end
            4: begin wb_we = 1'b1; wb_rd = 5'd0; end
            default: wb_we = 1'b0;
        endcase
        wb_data = fwd_data;
        tick();
        wb_we = 1'b0;
        exp1 = (rs1 == 5'd0) ? 32'd0 : rf_mem[rs1];
        exp2 = (rs2 == 5'd0) ? 32'd0 : rf_mem[rs2];
        checkOutput("no_early_valid", 32'(early), 32'd0);
        checkOutput("valid_at_latency", 32'(out_valid), 32'd1);
        checkOutput("pc", out_pc, pc);
        checkOutput("rs1_data", out_rs1_data, exp1);
        checkOutput("rs2_data", out_rs2_data, exp2);
        checkOutput("imm", out_imm, model_imm(ins));
        checkOutput("rd_f3_f7", {24'd0, out_rd, out_funct3}, {24'd0, ins[11:7], ins[14:12]});
        checkOutput("funct7b5", 32'(out_funct7b5), 32'(ins[30]));
        checkOutput("ctrl", 32'({out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                                 out_branch, out_jump, out_illegal}), 32'(model_ctrl(ins[6:0])));
    endtask

    logic [6:0]   ops [13] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63,
                               7'h67, 7'h6F, 7'h7F, 7'h73, 7'h0B, 7'h00};
    logic [144:0] snap;
    logic [31:0]  r;

    initial begin
        // Reset behaviour: handshake closed, bundle zero, addresses zero
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'hFFD08293;
        tick(); tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_rf_addr", {22'd0, rf_a1, rf_a2}, 32'd0);
        checkOutput("reset_imm", out_imm, 32'd0);
        checkOutput("reset_ctrl", 32'({out_alu_src, out_reg_write, out_mem_read, out_mem_write,
                                       out_branch, out_jump, out_illegal}), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // addi x5,x1,-3 with x1 = 10
        applyStimulus(32'hFFD08293, 32'h100, 0, 0, 32'd0);
        checkOutput("addi_rs1", out_rs1_data, 32'd10);
        checkOutput("addi_imm", out_imm, 32'hFFFFFFFD);

        // sw x2,8(x3) with two write cycles in S_READ
        applyStimulus(32'h0021A423, 32'h104, 2, 0, 32'd0);
        checkOutput("sw_imm", out_imm, 32'd8);

        // addi with same-cycle writeback to x1 in S_DATA
        applyStimulus(32'hFFD08293, 32'h108, 0, 1, 32'h55);
        checkOutput("fwd_rs1", out_rs1_data, 32'h55);

        // rs1 = x0 with a writeback targeting x0
        applyStimulus(32'h00700293, 32'h10C, 1, 4, 32'd7);
        checkOutput("x0_rs1", out_rs1_data, 32'd0);

        // Backpressure: bundle must hold, no new instruction accepted
        snap = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd, out_funct3, out_funct7b5,
                out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal};
        in_valid = 1'b1; in_instr = 32'h0021A423; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wb_we = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
            tick();
            checkOutput("hold_stable", 32'(snap == {out_pc, out_rs1_data, out_rs2_data, out_imm,
                        out_rd, out_funct3, out_funct7b5, out_alu_src, out_reg_write,
                        out_mem_read, out_mem_write, out_branch, out_jump, out_illegal}), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
        end
        wb_we = 1'b0;

        // Flush with a live offer: offer ignored, stage empties
        flush = 1'b1; out_ready = 1'b1;
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_empty", 32'(in_ready), 32'd1);
        tick();
        checkOutput("flush_stays_empty", 32'(out_valid), 32'd0);

        // Unknown opcode
        applyStimulus(32'h12345FFF, 32'h200, 0, 0, 32'd0);
        checkOutput("illegal_flag", 32'(out_illegal), 32'd1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 12)];
            applyStimulus(r, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b1; in_valid = 1'b0;
                tick();
                out_ready = 1'b0;
                checkOutput("drain_valid", 32'(out_valid), 32'd0);
            end
        end

        // Reset in the middle of a transaction discards it
        in_valid = 1'b1; in_instr = 32'hFFD08293; out_ready = 1'b1;
        #1;
        while (!in_ready) tick();
        tick();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_pc", out_pc, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("midrst_idle", {30'd0, out_valid, in_ready}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
